// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with multdiv wait and load-use detection
module pipe_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      d_insn,
    input  logic [31:0]      x_insn,
    input  logic             x_branch_taken,
    input  logic             md_ready,
    output logic             pc_we,
    output logic             fd_we,
    output logic             dx_we,
    output logic             xm_we,
    output logic             fd_nop,
    output logic             dx_nop,
    output logic             md_start,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WC_W = (MD_TIMEOUT < 1) ? 1 : $clog2(MD_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MD_TIMEOUT);
    localparam logic [WC_W-1:0] WC_PRE  = WC_W'(MD_TIMEOUT - 1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    typedef enum logic {S_RUN, S_MD_WAIT} state_t;

    state_t           r_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_md_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [4:0] w_x_op, w_x_rd, w_x_aluop;
    logic [4:0] w_d_op, w_d_rd, w_d_rs, w_d_rt;
    logic       w_src_rs, w_src_rt, w_src_rd;
    logic       w_x_md, w_load_use, w_wait_done;
    logic       w_unused_bits;

    assign w_x_op    = x_insn[31:27];
    assign w_x_rd    = x_insn[26:22];
    assign w_x_aluop = x_insn[6:2];
    assign w_d_op    = d_insn[31:27];
    assign w_d_rd    = d_insn[26:22];
    assign w_d_rs    = d_insn[21:17];
    assign w_d_rt    = d_insn[16:12];
    assign w_unused_bits = &{1'b0, d_insn[11:0], x_insn[21:7], x_insn[1:0]};

    assign w_x_md = (w_x_op == OP_RTYPE) && (w_x_aluop == 5'b00110 || w_x_aluop == 5'b00111);

    // Which fields of the decode instruction are read as source registers
    always_comb begin
        w_src_rs = 1'b0;
        w_src_rt = 1'b0;
        w_src_rd = 1'b0;
        case (w_d_op)
            OP_RTYPE:                begin w_src_rs = 1'b1; w_src_rt = 1'b1; end
            OP_ADDI, OP_LW:          w_src_rs = 1'b1;
            OP_SW, OP_BNE, OP_BLT:   begin w_src_rs = 1'b1; w_src_rd = 1'b1; end
            OP_JR:                   w_src_rd = 1'b1;
            default:                 ;
        endcase
    end

    assign w_load_use = (w_x_op == OP_LW) && (w_x_rd != 5'd0) &&
                        ((w_src_rs && w_d_rs == w_x_rd) ||
                         (w_src_rt && w_d_rt == w_x_rd) ||
                         (w_src_rd && w_d_rd == w_x_rd));

    // A timeout releases the pipe exactly as a late md_ready would
    assign w_wait_done = md_ready || (r_wait_cnt == WC_LAST);

    always_comb begin
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        dx_we    = 1'b0;
        xm_we    = 1'b0;
        fd_nop   = 1'b0;
        dx_nop   = 1'b0;
        md_start = 1'b0;
        if (reset) begin
            case (r_state)
                S_RUN: begin
                    if (x_branch_taken) begin
                        {pc_we, fd_we, dx_we, xm_we} = 4'b1111;
                        fd_nop = 1'b1;
                        dx_nop = 1'b1;
                    end else if (w_x_md) begin
                        md_start = 1'b1;
                    end else if (w_load_use) begin
                        dx_we  = 1'b1;
                        xm_we  = 1'b1;
                        dx_nop = 1'b1;
                    end else begin
                        {pc_we, fd_we, dx_we, xm_we} = 4'b1111;
                    end
                end
                S_MD_WAIT: begin
                    if (w_wait_done) {pc_we, fd_we, dx_we, xm_we} = 4'b1111;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_RUN;
            r_wait_cnt   <= '0;
            r_md_timeout <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            if (!pc_we && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            case (r_state)
                S_RUN: begin
                    if (!x_branch_taken && w_x_md) begin
                        r_state    <= S_MD_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_MD_WAIT: begin
                    if (w_wait_done) begin
                        r_state <= S_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                        if (r_wait_cnt == WC_PRE) r_md_timeout <= 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign md_timeout   = r_md_timeout;
    assign stall_cycles = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int MD_TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] d_insn = '0;
    logic [31:0] x_insn = '0;
    logic        x_branch_taken = 1'b0;
    logic        md_ready = 1'b0;

    logic        pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start, md_timeout;
    logic [15:0] stall_cycles;
    logic        n_pc_we, n_fd_we, n_dx_we, n_xm_we, n_fd_nop, n_dx_nop, n_md_start, n_md_timeout;
    logic [3:0]  stall4;

    int total = 0;
    int bad   = 0;

    bit m_wait = 0;
    bit m_to   = 0;
    int m_waited = 0;
    int m_stalls = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .d_insn(d_insn), .x_insn(x_insn),
        .x_branch_taken(x_branch_taken), .md_ready(md_ready),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we),
        .fd_nop(fd_nop), .dx_nop(dx_nop), .md_start(md_start),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .d_insn(d_insn), .x_insn(x_insn),
        .x_branch_taken(x_branch_taken), .md_ready(md_ready),
        .pc_we(n_pc_we), .fd_we(n_fd_we), .dx_we(n_dx_we), .xm_we(n_xm_we),
        .fd_nop(n_fd_nop), .dx_nop(n_dx_nop), .md_start(n_md_start),
        .md_timeout(n_md_timeout), .stall_cycles(stall4)
    );

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int alu);
        return {op[4:0], rd[4:0], rs[4:0], rt[4:0], 5'd0, alu[4:0], 2'b00};
    endfunction

    function automatic bit is_md(input logic [31:0] i);
        return (i[31:27] == 5'd0) && (i[6:2] == 5'd6 || i[6:2] == 5'd7);
    endfunction

    function automatic bit load_use(input logic [31:0] x, input logic [31:0] d);
        int srcs[$];
        int xrd;
        int op;
        xrd = int'(x[26:22]);
        op  = int'(d[31:27]);
        if (x[31:27] != 5'd8 || xrd == 0) return 0;
        if (op == 0)                  begin srcs.push_back(int'(d[21:17])); srcs.push_back(int'(d[16:12])); end
        if (op == 5 || op == 8)       srcs.push_back(int'(d[21:17]));
        if (op == 7 || op == 2 || op == 6) begin srcs.push_back(int'(d[21:17])); srcs.push_back(int'(d[26:22])); end
        if (op == 4)                  srcs.push_back(int'(d[26:22]));
        foreach (srcs[k]) if (srcs[k] == xrd) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] x, input logic [31:0] d,
                         input logic br, input logic rdy);
        @(posedge clk);
        #2;
        reset = rst; x_insn = x; d_insn = d; x_branch_taken = br; md_ready = rdy;
        #1;
    endtask

    // Expected {pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start}, checked every cycle
    always @(negedge clk) begin
        logic [6:0] e;
        bit rel;
        e   = 7'b0;
        rel = 0;
        if (reset !== 1'b1) begin
            m_wait = 0; m_to = 0; m_waited = 0; m_stalls = 0;
        end else if (m_wait) begin
            rel = md_ready || (m_waited == MD_TO);
            e   = rel ? 7'b1111000 : 7'b0000000;
        end else if (x_branch_taken) e = 7'b1111110;
        else if (is_md(x_insn))       e = 7'b0000001;
        else if (load_use(x_insn, d_insn)) e = 7'b0011010;
        else                          e = 7'b1111000;

        chk("ctl", 32'({pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start}), 32'(e));
        chk("md_timeout", 32'(md_timeout), 32'(m_to));
        chk("stall_cycles", 32'(stall_cycles), (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
        chk("stall4", 32'(stall4), (m_stalls > 15) ? 32'd15 : 32'(m_stalls));

        if (reset === 1'b1) begin
            if (!e[6]) m_stalls++;
            if (m_wait) begin
                if (rel) m_wait = 0;
                else begin
                    m_waited++;
                    if (m_waited == MD_TO) m_to = 1;
                end
            end else if (e[0]) begin
                m_wait = 1;
                m_waited = 0;
            end
        end
    end

    initial begin
        logic [31:0] nop_i, lw5, add_dep, mult_i, div_i;
        int n, starts;
        bit found;
        int ops[11];
        int alus[4];
        ops  = '{0, 2, 4, 5, 6, 7, 8, 8, 8, 1, 3};
        alus = '{0, 6, 7, 1};
        nop_i   = 32'h0;
        lw5     = mk(8, 5, 0, 0, 0);
        add_dep = mk(0, 1, 5, 2, 0);
        mult_i  = mk(0, 4, 1, 2, 6);
        div_i   = mk(0, 4, 1, 2, 7);

        drive(0, nop_i, nop_i, 0, 0);
        drive(0, nop_i, nop_i, 1, 1);
        chk("rst_ctl", 32'({pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start}), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);

        drive(1, nop_i, nop_i, 0, 0);
        chk("run_default", 32'({pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start}), 32'b1111000);

        drive(1, lw5, add_dep, 0, 0);
        chk("lu_pc_we", 32'(pc_we), 32'd0);
        chk("lu_fd_we", 32'(fd_we), 32'd0);
        chk("lu_dx_nop", 32'(dx_nop), 32'd1);
        drive(1, nop_i, nop_i, 0, 0);
        chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

        drive(1, lw5, add_dep, 1, 0);
        chk("br_wins", 32'({pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start}), 32'b1111110);

        drive(1, mk(8, 0, 3, 0, 0), mk(0, 1, 0, 0, 0), 0, 0);
        chk("lw_r0_no_stall", 32'(pc_we), 32'd1);
        drive(1, nop_i, nop_i, 0, 0);

        drive(1, mult_i, nop_i, 0, 0);
        n = 1; starts = int'(md_start);
        for (int k = 1; k <= 20; k++) begin
            drive(1, mult_i, nop_i, 0, k == 6);
            starts += int'(md_start);
            if (pc_we) break;
            n++;
        end
        chk("md_stall_len", 32'(n), 32'd6);
        chk("md_start_count", 32'(starts), 32'd1);
        chk("md_no_timeout", 32'(md_timeout), 32'd0);
        drive(1, nop_i, nop_i, 0, 0);

        drive(1, div_i, nop_i, 0, 0);
        n = 1; found = 0;
        for (int k = 1; k <= 100; k++) begin
            drive(1, div_i, nop_i, 0, 0);
            if (pc_we) begin found = 1; break; end
            n++;
        end
        chk("to_released", 32'(found), 32'd1);
        chk("to_stall_len", 32'(n), 32'd41);
        chk("to_flag", 32'(md_timeout), 32'd1);
        drive(1, nop_i, nop_i, 0, 0);
        chk("to_sticky", 32'(md_timeout), 32'd1);
        chk("stall_total", 32'(stall_cycles), 32'd48);
        chk("stall4_sat", 32'(stall4), 32'd15);

        drive(1, mult_i, nop_i, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, mult_i, nop_i, 0, 0);
        drive(0, mult_i, nop_i, 0, 1);
        chk("mid_rst_ctl", 32'({pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start}), 32'd0);
        chk("mid_rst_to", 32'(md_timeout), 32'd0);
        chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
        drive(0, mult_i, nop_i, 0, 0);
        drive(1, nop_i, nop_i, 0, 0);
        chk("post_rst_run", 32'({pc_we, fd_we, dx_we, xm_we, fd_nop, dx_nop, md_start}), 32'b1111000);
        drive(1, nop_i, nop_i, 0, 0);
        chk("post_rst_stall", 32'(stall_cycles), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] xi, di;
            xi = mk(ops[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), alus[$urandom_range(0, 3)]);
            di = mk(ops[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 0);
            drive($urandom_range(0, 999) >= 3, xi, di, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
